// File: rtl/sevenseg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan_pkg
//  Description : Shared definitions for the seven-segment scan driver:
//                blank segment pattern, scan state encoding and the
//                dwell-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_scan_pkg;

    // Active-low segments: all ones means every segment dark.
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Width of a counter that must reach max(a, b) - 1; never narrower than 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage : sevenseg_scan_pkg
`default_nettype wire

// File: rtl/scan_dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module      : scan_dwell_counter
//  Description : Loadable up-counter with a synchronous clear and a
//                terminal flag that compares the count against a limit
//                supplied at run time.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_clear       - synchronous clear to zero (highest priority)
//                i_load        - load i_load_val
//                i_load_val    - value to load
//                i_inc         - increment by one
//                i_limit       - runtime terminal value
//                o_count       - current count
//                o_terminal    - high while o_count == i_limit
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_dwell_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == i_limit);

endmodule : scan_dwell_counter
`default_nettype wire

// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scan
//  Description : Time-multiplexed scan driver for a common-anode display.
//                Each digit is lit for ON_CYCLES, then every anode is off
//                for BLANK_CYCLES to avoid ghosting, round-robin forever.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                i_enable        - scanning enabled; low forces blank
//                i_sevenseg      - packed patterns, digit i at [7i+6:7i]
//                o_anodes        - active-low digit enables (one-cold)
//                o_cathodes      - active-low segment lines
//                o_digit_idx     - index of current / next digit
//                o_frame_start   - one-cycle pulse when digit 0 lights
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int ON_CYCLES    = 1000,
    parameter int BLANK_CYCLES = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [7*DIGITS-1:0]       i_sevenseg,
    output logic [DIGITS-1:0]         o_anodes,
    output logic [6:0]                o_cathodes,
    output logic [$clog2(DIGITS)-1:0] o_digit_idx,
    output logic                      o_frame_start
);

    localparam int CNT_W = cnt_width(ON_CYCLES, BLANK_CYCLES);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  c_ON_LIMIT    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_BLANK_LIMIT = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  c_LAST_IDX    = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] c_ONE         = DIGITS'(1);

    scan_state_t       r_state;
    scan_state_t       w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [DIGITS-1:0] r_anodes;
    logic [DIGITS-1:0] w_anodes_next;
    logic [6:0]        r_cathodes;
    logic [6:0]        w_cathodes_next;
    logic              r_frame_start;
    logic              w_frame_next;

    logic              w_cnt_clear;
    logic [CNT_W-1:0]  w_limit;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_terminal;

    logic [6:0]        w_seg [DIGITS];

    // Unpack the flat segment bus into one entry per digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign w_seg[g] = i_sevenseg[7*g +: 7];
    end

    assign w_limit = (r_state == ST_SHOW) ? c_ON_LIMIT : c_BLANK_LIMIT;

    scan_dwell_counter #(
        .WIDTH (CNT_W)
    ) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cnt_clear),
        .i_load     (1'b0),
        .i_load_val ({CNT_W{1'b0}}),
        .i_inc      (1'b1),
        .i_limit    (w_limit),
        .o_count    (w_cnt),
        .o_terminal (w_terminal)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Segment data is captured only on
    // the BLANK->SHOW transition so a digit never tears mid-dwell, and the
    // anode-off / cathode-blank happen on the same edge when leaving SHOW.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_anodes_next   = r_anodes;
        w_cathodes_next = r_cathodes;
        w_frame_next    = 1'b0;
        w_cnt_clear     = 1'b0;

        if (!i_enable) begin
            // Index is held so scanning resumes on the same digit.
            w_state_next    = ST_BLANK;
            w_cnt_clear     = 1'b1;
            w_anodes_next   = '1;
            w_cathodes_next = SEG_OFF;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (w_terminal) begin
                        w_state_next    = ST_SHOW;
                        w_cnt_clear     = 1'b1;
                        w_cathodes_next = w_seg[r_idx];
                        w_anodes_next   = ~(c_ONE << r_idx);
                        w_frame_next    = (r_idx == '0);
                    end
                end
                ST_SHOW: begin
                    if (w_terminal) begin
                        w_state_next    = ST_BLANK;
                        w_cnt_clear     = 1'b1;
                        w_anodes_next   = '1;
                        w_cathodes_next = SEG_OFF;
                        w_idx_next      = (r_idx == c_LAST_IDX) ? '0
                                                               : r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    w_state_next = ST_BLANK;
                    w_cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BLANK;
            r_idx         <= '0;
            r_anodes      <= '1;
            r_cathodes    <= SEG_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_anodes      <= w_anodes_next;
            r_cathodes    <= w_cathodes_next;
            r_frame_start <= w_frame_next;
        end
    end

    assign o_anodes      = r_anodes;
    assign o_cathodes    = r_cathodes;
    assign o_digit_idx   = r_idx;
    assign o_frame_start = r_frame_start;

endmodule : sevenseg_scan
`default_nettype wire
